// File: rtl/stream_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Interface   : stream_traffic_gen_if
// Description : valid/ready stream channel carrying payload and a LAST marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_traffic_gen_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/stream_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : stream_traffic_gen
// Description : Throttled valid/ready stream source with LFSR, incrementing or
//               fixed-pattern payload, bounded runs and an accepted-beat count.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_traffic_gen #(
    parameter int          DATA_W  = 32,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] SEED    = 32'h1ACE_B00C,
    parameter logic [31:0] PATTERN = 32'hA5A5_5A5A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [7:0]           throttle,
    input  logic [CNT_W-1:0]     num_beats,
    output logic [CNT_W-1:0]     sent_count,
    output logic                 done,
    stream_traffic_gen_if.master strm
);

    localparam logic [31:0]          c_taps    = 32'h8020_0003;
    localparam logic [31:0]          c_seed    = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int                   c_reps    = (DATA_W + 31) / 32;
    localparam logic [c_reps*32-1:0] c_pat_rep = {c_reps{PATTERN}};
    localparam logic [DATA_W-1:0]    c_pattern = c_pat_rep[DATA_W-1:0];
    localparam logic [CNT_W-1:0]     c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_lfsr;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_num;
    logic [DATA_W-1:0]   r_inc;

    logic [31:0]         w_lfsr_next;
    logic [c_reps*32-1:0] w_rand_rep;
    logic [DATA_W-1:0]   w_rand;
    logic                w_xfer;
    logic                w_slot;
    logic                w_gate;
    logic                w_more;
    logic                w_is_last;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [DATA_W-1:0]   w_inc_next;
    logic [DATA_W-1:0]   w_new_data;

    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_taps : 32'h0);
    assign w_rand_rep  = {c_reps{r_lfsr}};
    assign w_rand      = w_rand_rep[DATA_W-1:0];

    assign w_xfer     = r_valid & strm.ready;
    assign w_slot     = ~r_valid | w_xfer;
    assign w_gate     = (r_lfsr[7:0] >= throttle);
    assign w_cnt_next = (w_xfer && (r_cnt != c_cnt_max)) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_inc_next = w_xfer ? r_inc + DATA_W'(1) : r_inc;

    // Index of the beat about to be loaded is the post-transfer accepted count.
    assign w_more    = (r_num == '0) || (w_cnt_next < r_num);
    assign w_is_last = (r_num != '0) && (w_cnt_next == r_num - CNT_W'(1));

    always_comb begin
        w_new_data = w_rand;
        case (mode)
            2'd1:    w_new_data = w_inc_next;
            2'd2:    w_new_data = c_pattern;
            default: w_new_data = w_rand;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= c_seed;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_num   <= '0;
            r_inc   <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b0;
                    if (enable) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_inc   <= '0;
                        r_num   <= num_beats;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_next;
                        r_inc <= w_inc_next;
                    end
                    if (w_xfer && r_last) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!enable) begin
                        // A pending beat stays offered until the sink takes it.
                        if (w_slot) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end else if (w_slot) begin
                        if (w_more && w_gate) begin
                            r_valid <= 1'b1;
                            r_data  <= w_new_data;
                            r_last  <= w_is_last;
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b1;
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign strm.data  = r_data;
    assign strm.valid = r_valid;
    assign strm.last  = r_last;
    assign sent_count = r_cnt;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stream_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_traffic_gen
// Description : Scoreboard bench for stream_traffic_gen (32-bit and 48-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_traffic_gen;

    localparam logic [31:0] c_seed = 32'h1ACE_B00C;
    localparam logic [31:0] c_taps = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default 32-bit payload, 16-bit counter
    logic        en_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic [7:0]  thr_a = 8'd0;
    logic [15:0] nb_a = 16'd0;
    logic [15:0] cnt_a;
    logic        done_a;
    stream_traffic_gen_if #(.DATA_W(32)) if_a ();

    stream_traffic_gen #(.DATA_W(32), .CNT_W(16), .SEED(c_seed)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_a),
        .mode       (mode_a),
        .throttle   (thr_a),
        .num_beats  (nb_a),
        .sent_count (cnt_a),
        .done       (done_a),
        .strm       (if_a)
    );

    // Instance B: 48-bit payload, 4-bit saturating counter
    logic        en_b = 1'b0;
    logic [1:0]  mode_b = 2'd2;
    logic [7:0]  thr_b = 8'd0;
    logic [3:0]  nb_b = 4'd0;
    logic [3:0]  cnt_b;
    logic        done_b;
    stream_traffic_gen_if #(.DATA_W(48)) if_b ();

    stream_traffic_gen #(.DATA_W(48), .CNT_W(4), .SEED(c_seed)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_b),
        .mode       (mode_b),
        .throttle   (thr_b),
        .num_beats  (nb_b),
        .sent_count (cnt_b),
        .done       (done_b),
        .strm       (if_b)
    );

    // Reference LFSR, free-running from reset release like the source's.
    logic [31:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= c_seed;
        else     m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? c_taps : 32'h0);
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? c_taps : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed { logic [31:0] data; logic last; } beat_a_t;
    typedef struct packed { logic [47:0] data; logic last; } beat_b_t;
    beat_a_t q_a[$];
    beat_b_t q_b[$];
    int      xc_a[$];
    int      n_xfer_b = 0;

    // Monitor A: pops on each handshake, checks the offer holds while stalled.
    initial begin : mon_a
        logic        hold;
        logic [31:0] hdata;
        logic        hlast;
        beat_a_t     e;
        hold = 1'b0; hdata = '0; hlast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", {63'd0, if_a.valid}, 64'd1);
                    chk("hold_data",  {32'd0, if_a.data},  {32'd0, hdata});
                    chk("hold_last",  {63'd0, if_a.last},  {63'd0, hlast});
                end
                if (if_a.valid && if_a.ready) begin
                    xc_a.push_back(cyc);
                    if (q_a.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_beat_a: got data %0h, expected no beat", if_a.data);
                    end else begin
                        e = q_a.pop_front();
                        chk("beat_a_data", {32'd0, if_a.data}, {32'd0, e.data});
                        chk("beat_a_last", {63'd0, if_a.last}, {63'd0, e.last});
                    end
                end
                hold  = if_a.valid && !if_a.ready;
                hdata = if_a.data;
                hlast = if_a.last;
            end
        end
    end

    initial begin : mon_b
        beat_b_t e;
        forever begin
            @(negedge clk);
            if (!rst && if_b.valid && if_b.ready) begin
                n_xfer_b++;
                if (q_b.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat_b: got data %0h, expected no beat", if_b.data);
                end else begin
                    e = q_b.pop_front();
                    chk("beat_b_data", {16'd0, if_b.data}, {16'd0, e.data});
                    chk("beat_b_last", {63'd0, if_b.last}, {63'd0, e.last});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget, input string name);
        int k;
        k = 0;
        while (!done_a && k < budget) begin
            step(1);
            k++;
        end
        chk(name, {63'd0, done_a}, 64'd1);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin : watchdog
        #3_000_000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        summary();
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n_pred;
        if_a.ready = 1'b0;
        if_b.ready = 1'b0;

        // Reset state
        step(2);
        chk("rst_valid", {63'd0, if_a.valid}, 64'd0);
        chk("rst_last",  {63'd0, if_a.last},  64'd0);
        chk("rst_done",  {63'd0, done_a},     64'd0);
        chk("rst_cnt",   {48'd0, cnt_a},      64'd0);
        chk("rst_data",  {32'd0, if_a.data},  64'd0);

        // Seed check: one random beat right after release; num_beats=1 gives last
        q_a.push_back('{data: lfsr_step(c_seed), last: 1'b1});
        rst = 1'b0; mode_a = 2'd0; thr_a = 8'd0; nb_a = 16'd1; if_a.ready = 1'b1; en_a = 1'b1;
        wait_done_a(20, "seed_done_timeout");
        chk("seed_cnt", {48'd0, cnt_a}, 64'd1);
        step(2);
        chk("done_hold_enable", {63'd0, done_a}, 64'd1);
        en_a = 1'b0;
        step(1);
        chk("done_clears", {63'd0, done_a}, 64'd0);
        step(1);

        // Incrementing, 4 beats back-to-back
        for (int i = 0; i < 4; i++) q_a.push_back('{data: 32'(i), last: (i == 3)});
        xc_a.delete();
        mode_a = 2'd1; nb_a = 16'd4; en_a = 1'b1;
        step(1);
        chk("lat_valid_low", {63'd0, if_a.valid}, 64'd0);
        step(1);
        chk("lat_valid_high", {63'd0, if_a.valid}, 64'd1);
        wait_done_a(20, "t2_done_timeout");
        chk("t2_cnt", {48'd0, cnt_a}, 64'd4);
        chk("t2_nxfer", 64'(xc_a.size()), 64'd4);
        if (xc_a.size() == 4)
            for (int i = 1; i < 4; i++) chk("t2_back_to_back", 64'(xc_a[i] - xc_a[i-1]), 64'd1);
        chk("t2_sb_empty", 64'(q_a.size()), 64'd0);
        en_a = 1'b0;
        step(2);

        // Async reset mid-run after 3 accepted beats with a 4th pending
        for (int i = 0; i < 3; i++) q_a.push_back('{data: 32'(i), last: 1'b0});
        mode_a = 2'd1; nb_a = 16'd0; if_a.ready = 1'b1; en_a = 1'b1;
        step(5);
        if_a.ready = 1'b0;
        chk("t1_cnt_before", {48'd0, cnt_a}, 64'd3);
        chk("t1_pending", {63'd0, if_a.valid}, 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t1_async_valid", {63'd0, if_a.valid}, 64'd0);
        chk("t1_async_last",  {63'd0, if_a.last},  64'd0);
        chk("t1_async_done",  {63'd0, done_a},     64'd0);
        chk("t1_async_cnt",   {48'd0, cnt_a},      64'd0);
        en_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1);
        chk("t1_sb_empty", 64'(q_a.size()), 64'd0);

        // Toggling ready, 8 beats
        for (int i = 0; i < 8; i++) q_a.push_back('{data: 32'(i), last: (i == 7)});
        mode_a = 2'd1; nb_a = 16'd8; en_a = 1'b1; if_a.ready = 1'b1;
        for (int k = 0; k < 80 && !done_a; k++) begin
            step(1);
            if_a.ready = ~if_a.ready;
        end
        chk("t3_done", {63'd0, done_a}, 64'd1);
        chk("t3_cnt", {48'd0, cnt_a}, 64'd8);
        chk("t3_sb_empty", 64'(q_a.size()), 64'd0);
        en_a = 1'b0; if_a.ready = 1'b0;
        step(2);

        // Enable drops while a beat is stalled
        q_a.push_back('{data: 32'd0, last: 1'b0});
        mode_a = 2'd1; nb_a = 16'd0; en_a = 1'b1;
        for (int k = 0; k < 10 && !if_a.valid; k++) step(1);
        chk("t5_valid_timeout", {63'd0, if_a.valid}, 64'd1);
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t5_held_valid", {63'd0, if_a.valid}, 64'd1);
            chk("t5_held_data", {32'd0, if_a.data}, 64'd0);
        end
        if_a.ready = 1'b1;
        step(1);
        if_a.ready = 1'b0;
        chk("t5_after_valid", {63'd0, if_a.valid}, 64'd0);
        chk("t5_cnt", {48'd0, cnt_a}, 64'd1);
        step(3);
        chk("t5_idle_valid", {63'd0, if_a.valid}, 64'd0);
        chk("t5_sb_empty", 64'(q_a.size()), 64'd0);

        // Random payload, throttle 0xFF: beat only when lfsr[7:0] == 0xFF
        n_pred = 0;
        mode_a = 2'd0; thr_a = 8'hFF; nb_a = 16'd0; if_a.ready = 1'b1; en_a = 1'b1;
        step(1);
        for (int k = 0; k < 10000; k++) begin
            if (m_lfsr[7:0] >= 8'hFF) begin
                q_a.push_back('{data: m_lfsr, last: 1'b0});
                n_pred++;
            end
            step(1);
        end
        en_a = 1'b0;
        step(3);
        chk("t4_duty_in_range", {63'd0, (n_pred >= 20 && n_pred <= 58)}, 64'd1);
        chk("t4_sb_empty", 64'(q_a.size()), 64'd0);
        if_a.ready = 1'b0;

        // 48-bit fixed pattern, unbounded, counter saturates at 15
        for (int i = 0; i < 20; i++) q_b.push_back('{data: 48'h5A5A_A5A5_5A5A, last: 1'b0});
        mode_b = 2'd2; nb_b = 4'd0; thr_b = 8'd0; if_b.ready = 1'b1; en_b = 1'b1;
        for (int k = 0; k < 60 && n_xfer_b < 20; k++) step(1);
        if_b.ready = 1'b0;
        chk("t6_nxfer", 64'(n_xfer_b), 64'd20);
        chk("t6_cnt_sat", {60'd0, cnt_b}, 64'd15);
        chk("t6_done", {63'd0, done_b}, 64'd0);
        chk("t6_pending_data", {16'd0, if_b.data}, {16'd0, 48'h5A5A_A5A5_5A5A});
        chk("t6_sb_empty", 64'(q_b.size()), 64'd0);
        en_b = 1'b0;
        step(2);

        summary();
        $finish;
    end

endmodule
`default_nettype wire
